cam_table_loader: RTL and testbench

- Write-side controller for the CAM-based adder cells.
- Sequences truth-table entries into a NUM_CELL-entry CAM array, one entry at a time, and reads each entry back to verify it.
- Raises table_valid once the whole table is verified. The lookup datapath uses table_valid as its "data loaded" qualifier in place of a bulk write_en.
- Supports full-adder and full-subtractor tables, selected by op_sel at start.

---
 rtl/cam_pkg.sv | 31 +++
 rtl/cam_table_loader_if.sv | 12 +
 rtl/cam_retry_cnt.sv | 20 ++
 rtl/cam_table_loader.sv | 102 ++++++++++
 tb/tb_cam_table_loader.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared constants, types and the truth-table entry function for the CAM adder cells.
// The lookup side reuses entry_f as its reference model.
package cam_pkg;
  localparam int NUM_CELL  = 8;
  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 2;
  localparam int MAX_RETRY = 3;
  localparam int RETRY_W   = $clog2(MAX_RETRY + 1);

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAIL  = 3'd5
  } state_e;

  // idx = {a,b,c}; bit0 = sum/diff, bit1 = carry/borrow
  function automatic logic [DATA_W-1:0] entry_f(op_e op, logic [ADDR_W-1:0] idx);
    logic a, b, c;
    a = idx[2];
    b = idx[1];
    c = idx[0];
    entry_f[0] = a ^ b ^ c;
    if (op == OP_SUB) entry_f[1] = (~a & b) | (~a & c) | (b & c);
    else              entry_f[1] = (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/cam_table_loader_if.sv
// Write/read port between the table loader (master) and the CAM array (slave).
interface cam_table_loader_if;
  import cam_pkg::*;
  logic              cam_we;
  logic              cam_re;
  logic [ADDR_W-1:0] cam_addr;
  logic [DATA_W-1:0] cam_wdata;
  logic [DATA_W-1:0] cam_rdata;

  modport master (output cam_we, cam_re, cam_addr, cam_wdata, input cam_rdata);
  modport slave  (input cam_we, cam_re, cam_addr, cam_wdata, output cam_rdata);
endinterface

// File: rtl/cam_retry_cnt.sv
// Per-entry retry counter; saturates at MAX_RETRY and flags exhaustion.
module cam_retry_cnt
  import cam_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_exhausted
);
  logic [RETRY_W-1:0] r_cnt;

  assign o_exhausted = (r_cnt == RETRY_W'(MAX_RETRY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_cnt <= '0;
    else if (i_clr)                  r_cnt <= '0;
    else if (i_inc && !o_exhausted)  r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/cam_table_loader.sv
// Writes each truth-table entry into the CAM, reads it back, retries on mismatch,
// and raises table_valid once every entry has verified.
module cam_table_loader
  import cam_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op_sel,
  input  logic               abort,
  cam_table_loader_if.master cam,
  output logic               busy,
  output logic               table_valid,
  output logic               done,
  output logic               error,
  output logic [ADDR_W-1:0]  err_addr
);
  state_e            r_state;
  op_e               r_op;
  logic [ADDR_W-1:0] r_idx;
  logic              r_done, r_valid, r_error;
  logic [ADDR_W-1:0] r_err_addr;

  logic [DATA_W-1:0] w_entry;
  logic w_check, w_match, w_last, w_idle_like, w_accept, w_exhausted;

  assign w_entry     = entry_f(r_op, r_idx);
  assign w_check     = (r_state == ST_CHECK);
  assign w_match     = (cam.cam_rdata == w_entry);
  assign w_last      = (r_idx == ADDR_W'(NUM_CELL - 1));
  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_FAIL);
  assign w_accept    = w_idle_like && start && !abort;

  cam_retry_cnt u_retry (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_accept || (w_check && w_match)),
    .i_inc       (w_check && !w_match && !abort),
    .o_exhausted (w_exhausted)
  );

  assign cam.cam_we    = (r_state == ST_WRITE);
  assign cam.cam_re    = (r_state == ST_READ);
  assign cam.cam_addr  = r_idx;
  assign cam.cam_wdata = (r_state == ST_WRITE) ? w_entry : '0;

  assign busy        = (r_state == ST_WRITE) || (r_state == ST_READ) || (r_state == ST_CHECK);
  assign table_valid = r_valid;
  assign done        = r_done;
  assign error       = r_error;
  assign err_addr    = r_err_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_ADD;
      r_idx      <= '0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
      r_err_addr <= '0;
    end else if (abort) begin
      // error/err_addr survive an abort so software can still inspect them
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_FAIL: if (start) begin
          r_op       <= op_e'(op_sel);
          r_idx      <= '0;
          r_error    <= 1'b0;
          r_err_addr <= '0;
          r_valid    <= 1'b0;
          r_state    <= ST_WRITE;
        end
        ST_WRITE: r_state <= ST_READ;
        ST_READ:  r_state <= ST_CHECK;
        ST_CHECK: begin
          if (w_match) begin
            if (w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_valid <= 1'b1;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_WRITE;
            end
          end else if (w_exhausted) begin
            r_state    <= ST_FAIL;
            r_error    <= 1'b1;
            r_err_addr <= r_idx;
          end else begin
            r_state <= ST_WRITE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cam_table_loader.sv
// Directed bench for cam_table_loader with a behavioural CAM that can corrupt readbacks.
module tb_cam_table_loader;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, op_sel = 1'b0, abort = 1'b0;
  logic       busy, table_valid, done, error;
  logic [2:0] err_addr;

  cam_table_loader_if cif();

  cam_table_loader dut (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .abort(abort),
    .cam(cif.master), .busy(busy), .table_valid(table_valid), .done(done),
    .error(error), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // CAM model: mode 0 ideal, 1 corrupts one readback of addr5, 2 returns 00 at addr6
  int         mode = 0;
  int         corrupt_at = 0;
  logic [1:0] mem [8];
  logic [1:0] wlog [8];
  int         wcnt [8];
  int         wtotal = 0, rd5cnt = 0, dcnt = 0, viol = 0;
  logic [1:0] rdata_r = 2'b00;

  initial for (int i = 0; i < 8; i++) begin mem[i] = 2'b00; wlog[i] = 2'b00; wcnt[i] = 0; end

  assign cif.cam_rdata = rdata_r;

  always @(posedge clk) begin
    if (cif.cam_we) begin
      mem[cif.cam_addr]  <= cif.cam_wdata;
      wlog[cif.cam_addr] <= cif.cam_wdata;
      wcnt[cif.cam_addr] <= wcnt[cif.cam_addr] + 1;
      wtotal <= wtotal + 1;
    end
    if (cif.cam_re) begin
      if (cif.cam_addr == 3'd5) rd5cnt <= rd5cnt + 1;
      if (mode == 1 && cif.cam_addr == 3'd5 && rd5cnt == corrupt_at) rdata_r <= ~mem[5];
      else if (mode == 2 && cif.cam_addr == 3'd6)                   rdata_r <= 2'b00;
      else                                                          rdata_r <= mem[cif.cam_addr];
    end
    if (cif.cam_we && cif.cam_re) viol <= viol + 1;
    if (done) dcnt <= dcnt + 1;
  end

  int total = 0, passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  logic [1:0] add_t [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
  logic [1:0] sub_t [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};

  // lat = clock edges from the start-accepting edge until busy drops
  task automatic do_load(input logic op, output int lat);
    @(posedge clk); #1 start = 1'b1; op_sel = op;
    @(posedge clk); #1 start = 1'b0; op_sel = 1'b0;
    chk("valid_drop_after_start", table_valid, 0);
    chk("busy_after_start", busy, 1);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (!busy) begin lat = n; break; end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, table_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_err_addr"}, err_addr, 0);
    chk({tag, "_we"}, cif.cam_we, 0);
    chk({tag, "_re"}, cif.cam_re, 0);
    chk({tag, "_addr"}, cif.cam_addr, 0);
    chk({tag, "_wdata"}, cif.cam_wdata, 0);
  endtask

  typedef struct {
    logic op; int mode; int lat; logic err; logic valid; int eaddr; int paddr; int pwr;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, wb[8], db, wbase;
    vecs[0] = '{op: 1'b0, mode: 0, lat: 24, err: 1'b0, valid: 1'b1, eaddr: 0, paddr: 7, pwr: 1};
    vecs[1] = '{op: 1'b1, mode: 0, lat: 24, err: 1'b0, valid: 1'b1, eaddr: 0, paddr: 2, pwr: 1};
    vecs[2] = '{op: 1'b1, mode: 1, lat: 27, err: 1'b0, valid: 1'b1, eaddr: 0, paddr: 5, pwr: 2};
    vecs[3] = '{op: 1'b0, mode: 2, lat: 30, err: 1'b1, valid: 1'b0, eaddr: 6, paddr: 6, pwr: 4};

    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset");
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      mode = vecs[v].mode;
      corrupt_at = rd5cnt;
      for (int i = 0; i < 8; i++) wb[i] = wcnt[i];
      db = dcnt;
      do_load(vecs[v].op, lat);
      chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      chk($sformatf("v%0d_done", v), done, vecs[v].valid);
      chk($sformatf("v%0d_valid", v), table_valid, vecs[v].valid);
      chk($sformatf("v%0d_error", v), error, vecs[v].err);
      chk($sformatf("v%0d_err_addr", v), err_addr, vecs[v].eaddr);
      chk($sformatf("v%0d_probe_writes", v), wcnt[vecs[v].paddr] - wb[vecs[v].paddr], vecs[v].pwr);
      for (int a = 0; a < (vecs[v].err ? 7 : 8); a++)
        chk($sformatf("v%0d_wdata_a%0d", v, a), wlog[a], vecs[v].op ? sub_t[a] : add_t[a]);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_once", v), dcnt - db, vecs[v].valid ? 1 : 0);
      chk($sformatf("v%0d_valid_hold", v), table_valid, vecs[v].valid);
      chk($sformatf("v%0d_busy_idle", v), busy, 0);
    end
    mode = 0;

    // abort while in FAIL keeps error and err_addr
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_fail_error_kept", error, 1);
    chk("abort_fail_err_addr_kept", err_addr, 6);
    chk("abort_fail_busy", busy, 0);

    // abort together with start at cycle 10 of a load
    @(posedge clk); #1 start = 1'b1; op_sel = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 chk("abort_pre_busy", busy, 1);
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1 abort = 1'b0; start = 1'b0;
    wbase = wtotal;
    chk("abort_busy", busy, 0);
    chk("abort_valid", table_valid, 0);
    chk("abort_done", done, 0);
    repeat (10) @(posedge clk);
    #1 chk("abort_no_writes", wtotal - wbase, 0);
    chk("abort_still_idle", busy, 0);
    do_load(1'b0, lat);
    chk("post_abort_latency", lat, 24);
    chk("post_abort_valid", table_valid, 1);

    // async reset in CHECK of entry 3
    @(posedge clk); #1 start = 1'b1; op_sel = 1'b1;
    @(posedge clk); #1 start = 1'b0; op_sel = 1'b0;
    repeat (11) @(posedge clk);
    #2 chk("rst_pre_busy", busy, 1);
    chk("rst_pre_addr", cif.cam_addr, 3);
    rst = 1'b1;
    #1 check_zero_outputs("rst_async");
    @(posedge clk); #1 rst = 1'b0;
    check_zero_outputs("rst_release");
    do_load(1'b1, lat);
    chk("post_rst_latency", lat, 24);
    chk("post_rst_valid", table_valid, 1);
    do_load(1'b0, lat);
    chk("relaunch_latency", lat, 24);
    chk("relaunch_valid", table_valid, 1);
    for (int a = 0; a < 8; a++) chk($sformatf("relaunch_wdata_a%0d", a), wlog[a], add_t[a]);

    chk("strobe_overlap", viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
